// File: rtl/demux_dispatcher.sv
// Single-word demultiplexer: routes each accepted word to one of four channels, addressed or round-robin.
// Latency: word accepted at edge N is presented in cycle N+1; at most one word per two cycles.
// Backpressure: holds the word until out_ready of its channel is high; in_ready is low while holding.
module demux_dispatcher #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_dest,
    input  logic             mode,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic [15:0]      xfer_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [15:0]      xfer_cnt_q, xfer_cnt_d;

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        sel_d      = sel_q;
        rr_ptr_d   = rr_ptr_q;
        xfer_cnt_d = xfer_cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    state_d = HOLD;
                    // Routing inputs are sampled only here; later changes cannot redirect the held word.
                    if (mode) begin
                        sel_d    = rr_ptr_q;
                        rr_ptr_d = rr_ptr_q + 2'd1;
                    end else begin
                        sel_d = in_dest;
                    end
                end
            end
            HOLD: begin
                if (out_ready[sel_q]) begin
                    state_d    = IDLE;
                    xfer_cnt_d = xfer_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            data_q     <= '0;
            sel_q      <= '0;
            rr_ptr_q   <= '0;
            xfer_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            sel_q      <= sel_d;
            rr_ptr_q   <= rr_ptr_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    // Outputs decode registered state only; out_ready never reaches an output combinationally.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign busy      = (state_q == HOLD);
    assign out_valid = busy ? (4'b0001 << sel_q) : 4'b0000;
    assign out_data  = data_q;
    assign xfer_cnt  = xfer_cnt_q;

endmodule
